// File: rtl/bitsim_col_sequencer.sv
// Bit-column issue sequencer: walks the non-zero bit columns of one signed weight
// vector MSB-first and emits the per-column mux/skip/accumulate controls for one MAC row.
module bitsim_col_sequencer #(
  parameter int DATA_WIDTH = 8,
  parameter int VEC_LENGTH = 16
) (
  input  logic                                   clk,
  input  logic                                   reset,
  input  logic                                   w_valid,
  output logic                                   w_ready,
  input  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0]  weight,
  input  logic [2:0]                             cfg_mul_const,
  input  logic                                   cfg_shift_mul,
  input  logic                                   cfg_en_mul,
  input  logic                                   stall,
  output logic                                   mac_en,
  output logic                                   load_accum,
  output logic [VEC_LENGTH/2-1:0][2:0]           act_sel,
  output logic [VEC_LENGTH/2-1:0]                act_val,
  output logic [VEC_LENGTH/8-1:0]                is_skip_zero,
  output logic [$clog2(DATA_WIDTH)-1:0]          column_idx,
  output logic                                   is_msb,
  output logic [2:0]                             mul_const,
  output logic                                   is_shift_mul,
  output logic                                   en_mul,
  output logic                                   done
);

  localparam int GROUPS = VEC_LENGTH / 8;
  localparam int SLOTS  = GROUPS * 4;
  localparam int CW     = $clog2(DATA_WIDTH);

  typedef enum logic [1:0] {IDLE, ISSUE, DRAIN} state_t;

  typedef struct packed {
    logic [SLOTS-1:0][2:0] sel;
    logic [SLOTS-1:0]      val;
    logic [GROUPS-1:0]     skip;
  } col_t;

  typedef struct packed {
    logic                  w_ready;
    logic                  mac_en;
    logic                  load_accum;
    logic [SLOTS-1:0][2:0] act_sel;
    logic [SLOTS-1:0]      act_val;
    logic [GROUPS-1:0]     skip;
    logic [CW-1:0]         col;
    logic                  is_msb;
    logic [2:0]            mul_const;
    logic                  shift;
    logic                  en_mul;
    logic                  done;
  } out_t;

  state_t                                state_q, state_d;
  logic [DATA_WIDTH-1:0]                 rem_q, rem_d;
  logic                                  pend_q, pend_d;
  out_t                                  out_q, out_d;
  logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] weight_q;
  logic                                  cfg_en_q;
  logic [DATA_WIDTH-1:0]                 mask;
  logic [CW-1:0]                         col_sel;
  col_t                                  cvec;

  function automatic logic [DATA_WIDTH-1:0] nz_cols(input logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w);
    logic [DATA_WIDTH-1:0] m;
    m = '0;
    for (int l = 0; l < VEC_LENGTH; l++) m = m | w[l];
    return m;
  endfunction

  // Highest set bit; an empty mask maps to the MSB column so an all-zero vector still issues once.
  function automatic logic [CW-1:0] top_col(input logic [DATA_WIDTH-1:0] m);
    logic [CW-1:0] r;
    r = CW'(DATA_WIDTH - 1);
    for (int b = 0; b < DATA_WIDTH; b++) if (m[b]) r = CW'(b);
    return r;
  endfunction

  // Encode the minority value of each 8-lane group into 4 mux slots: slot = max(i, p-4), sel = p - slot.
  function automatic col_t build_col(input logic [VEC_LENGTH-1:0][DATA_WIDTH-1:0] w,
                                     input logic [CW-1:0] c);
    col_t       r;
    logic [7:0] tgt;
    int         k, i, s;
    r = '0;
    for (int g = 0; g < GROUPS; g++) begin
      k = 0;
      for (int j = 0; j < 8; j++) begin
        tgt[j] = w[8*g+j][c];
        k = k + (tgt[j] ? 1 : 0);
      end
      if (k <= 4) r.skip[g] = 1'b1;
      else        tgt = ~tgt;
      i = 0;
      for (int j = 0; j < 8; j++) begin
        if (tgt[j]) begin
          s = (j - 4 > i) ? j - 4 : i;
          for (int t = 0; t < 4; t++) begin
            if (t == s) begin
              r.val[4*g+t] = 1'b1;
              r.sel[4*g+t] = 3'(j - t);
            end
          end
          i = i + 1;
        end
      end
    end
    return r;
  endfunction

  always_comb begin
    state_d     = state_q;
    rem_d       = rem_q;
    pend_d      = pend_q;
    out_d       = out_q;
    out_d.mac_en = 1'b0;
    out_d.done  = 1'b0;
    mask        = '0;
    col_sel     = '0;
    cvec        = '0;
    case (state_q)
      IDLE: begin
        out_d         = '0;
        out_d.w_ready = 1'b1;
        if (w_valid) begin
          mask            = nz_cols(weight);
          col_sel         = top_col(mask);
          cvec            = build_col(weight, col_sel);
          rem_d           = mask & ~(DATA_WIDTH'(1) << col_sel);
          pend_d          = 1'b1;
          state_d         = ISSUE;
          out_d.w_ready   = 1'b0;
          out_d.mac_en    = 1'b1;
          out_d.act_sel   = cvec.sel;
          out_d.act_val   = cvec.val;
          out_d.skip      = cvec.skip;
          out_d.col       = col_sel;
          out_d.is_msb    = (col_sel == CW'(DATA_WIDTH - 1));
          out_d.mul_const = cfg_mul_const;
          out_d.shift     = cfg_shift_mul;
        end
      end
      ISSUE: begin
        if (!stall) begin
          out_d.mac_en     = 1'b1;
          out_d.load_accum = pend_q;
          out_d.en_mul     = pend_q & cfg_en_q;
          pend_d           = 1'b0;
          if (rem_q != '0) begin
            col_sel       = top_col(rem_q);
            cvec          = build_col(weight_q, col_sel);
            rem_d         = rem_q & ~(DATA_WIDTH'(1) << col_sel);
            out_d.act_sel = cvec.sel;
            out_d.act_val = cvec.val;
            out_d.skip    = cvec.skip;
            out_d.col     = col_sel;
            out_d.is_msb  = (col_sel == CW'(DATA_WIDTH - 1));
          end else begin
            state_d       = DRAIN;
            out_d.act_sel = '0;
            out_d.act_val = '0;
            out_d.skip    = '1;
            out_d.col     = '0;
            out_d.is_msb  = 1'b0;
          end
        end
      end
      DRAIN: begin
        if (!stall) begin
          state_d       = IDLE;
          out_d         = '0;
          out_d.w_ready = 1'b1;
          out_d.done    = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q       <= IDLE;
      rem_q         <= '0;
      pend_q        <= 1'b0;
      out_q         <= '0;
      out_q.w_ready <= 1'b1;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      pend_q  <= pend_d;
      out_q   <= out_d;
    end
  end

  always_ff @(posedge clk) begin
    if (state_q == IDLE && w_valid) begin
      weight_q <= weight;
      cfg_en_q <= cfg_en_mul;
    end
  end

  assign w_ready      = out_q.w_ready;
  assign mac_en       = out_q.mac_en;
  assign load_accum   = out_q.load_accum;
  assign act_sel      = out_q.act_sel;
  assign act_val      = out_q.act_val;
  assign is_skip_zero = out_q.skip;
  assign column_idx   = out_q.col;
  assign is_msb       = out_q.is_msb;
  assign mul_const    = out_q.mul_const;
  assign is_shift_mul = out_q.shift;
  assign en_mul       = out_q.en_mul;
  assign done         = out_q.done;

endmodule
